// File: rtl/p4_router_pkg.sv
// p4_router_pkg -- shared types and constants for the P4 router egress path.
//   egr_demux_state_t : egress demux FSM state encoding (IDLE/DECIDE/FORWARD/DROP)
//   EGR_SPEC_DROP     : all-ones egress spec, always treated as "drop"
//   CNT_MAX / sat_inc : saturating 32-bit packet counter helpers
package p4_router_pkg;

    typedef logic [1:0] egr_demux_state_t;

    localparam egr_demux_state_t ST_IDLE    = 2'd0;
    localparam egr_demux_state_t ST_DECIDE  = 2'd1;
    localparam egr_demux_state_t ST_FORWARD = 2'd2;
    localparam egr_demux_state_t ST_DROP    = 2'd3;

    // Wide enough for any egress-spec width; users slice the low bits.
    localparam logic [63:0] EGR_SPEC_DROP = '1;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == CNT_MAX) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/p4_router_egress_demux_if.sv
// AXIS_int -- AXI-Stream bus bundle used on both sides of the egress demux.
//   Master : drives tdata/tkeep/tvalid/tlast, samples tready
//   Slave  : samples tdata/tkeep/tvalid/tlast, drives tready
interface AXIS_int #(
    parameter int DATA_BYTES = 64
);
    logic [8*DATA_BYTES-1:0] tdata;
    logic [DATA_BYTES-1:0]   tkeep;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport Master (output tdata, tkeep, tvalid, tlast, input tready);
    modport Slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/p4_router_meta_fifo.sv
// p4_router_meta_fifo -- synchronous show-ahead FIFO for per-packet metadata.
//   clk, srst : clock and synchronous active-high reset (empties the FIFO)
//   wr_en/wr_data : push; accepted when not full, or when full and popping
//   rd_en/rd_data : pop; rd_data always shows the head entry while !empty
//   full, empty   : occupancy flags
module p4_router_meta_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_rd;
    logic             do_wr;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_data = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end
endmodule

// File: rtl/p4_router_egress_demux.sv
// p4_router_egress_demux -- routes each packet from the VNP4 wrapper to one of
// NUM_PORTS AXIS egress ports according to its egress-spec metadata, or drops it.
//   clk, sreset                 : clock, synchronous active-high reset
//   packet_data_in              : AXIS slave, packet beats
//   user_metadata_in_*          : per-packet {egr_spec, ing_port} with valid strobe (no ready)
//   packet_data_out[NUM_PORTS]  : AXIS master egress ports
//   fwd_pkt_count/drop_pkt_count: saturating packet counters
//   meta_overflow               : one-cycle pulse when a metadata strobe is lost
module p4_router_egress_demux
    import p4_router_pkg::*;
#(
    parameter int NUM_PORTS               = 4,
    parameter int EGR_SPEC_METADATA_WIDTH = 8,
    parameter int ING_PORT_METADATA_WIDTH = 8,
    parameter int DATA_BYTES              = 64,
    parameter int LOOPBACK_EN             = 0,
    parameter int META_FIFO_DEPTH         = 4
) (
    input  logic                               clk,
    input  logic                               sreset,
    AXIS_int.Slave                             packet_data_in,
    input  logic [EGR_SPEC_METADATA_WIDTH-1:0] user_metadata_in_egr_spec,
    input  logic [ING_PORT_METADATA_WIDTH-1:0] user_metadata_in_ing_port,
    input  logic                               user_metadata_in_valid,
    AXIS_int.Master                            packet_data_out [NUM_PORTS],
    output logic [31:0]                        fwd_pkt_count,
    output logic [31:0]                        drop_pkt_count,
    output logic                               meta_overflow
);
    localparam int EW     = EGR_SPEC_METADATA_WIDTH;
    localparam int IW     = ING_PORT_METADATA_WIDTH;
    localparam int PORT_W = $clog2(NUM_PORTS);
    localparam int EW1    = EW + 1;
    localparam int CMP_W  = (EW > IW) ? EW : IW;

    generate
        if (NUM_PORTS < 2 || NUM_PORTS > 16) begin : g_chk_ports
            $error("NUM_PORTS must be in 2..16");
        end
        if (EW < PORT_W) begin : g_chk_egr_w
            $error("EGR_SPEC_METADATA_WIDTH too narrow for NUM_PORTS");
        end
        if (META_FIFO_DEPTH < 2 || (META_FIFO_DEPTH & (META_FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
            $error("META_FIFO_DEPTH must be a power of 2 (>= 2)");
        end
        if ($bits(packet_data_in.tkeep) != DATA_BYTES) begin : g_chk_in_bytes
            $error("packet_data_in width differs from DATA_BYTES");
        end
    endgenerate

    egr_demux_state_t  state_reg;
    logic [EW-1:0]     egr_reg;
    logic [IW-1:0]     ing_reg;
    logic [PORT_W-1:0] sel_port_reg;
    logic [31:0]       fwd_cnt_reg;
    logic [31:0]       drop_cnt_reg;
    logic              meta_overflow_reg;

    logic [EW+IW-1:0]     fifo_rd_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 in_ready;
    logic                 pop;
    logic                 fwd_ok;
    logic [NUM_PORTS-1:0] out_ready_vec;

    p4_router_meta_fifo #(
        .WIDTH (EW + IW),
        .DEPTH (META_FIFO_DEPTH)
    ) u_meta_fifo (
        .clk     (clk),
        .srst    (sreset),
        .wr_en   (user_metadata_in_valid),
        .wr_data ({user_metadata_in_egr_spec, user_metadata_in_ing_port}),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Sentinel and out-of-range specs drop; loopback drops unless enabled.
    assign fwd_ok = (egr_reg != EGR_SPEC_DROP[EW-1:0]) &&
                    (EW1'(egr_reg) < EW1'(NUM_PORTS)) &&
                    ((LOOPBACK_EN != 0) || (CMP_W'(egr_reg) != CMP_W'(ing_reg)));

    always_comb begin
        in_ready = 1'b0;
        case (state_reg)
            ST_FORWARD: in_ready = out_ready_vec[sel_port_reg];
            ST_DROP:    in_ready = 1'b1;
            default:    in_ready = 1'b0;
        endcase
        // Gated by reset so an in-flight beat is never consumed by an aborting cycle.
        in_ready = in_ready && !sreset;
    end

    assign packet_data_in.tready = in_ready;
    assign pop = packet_data_in.tvalid && in_ready && packet_data_in.tlast;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_out
            if ($bits(packet_data_out[gi].tkeep) != DATA_BYTES) begin : g_chk_out_bytes
                $error("packet_data_out width differs from DATA_BYTES");
            end
            assign packet_data_out[gi].tdata  = packet_data_in.tdata;
            assign packet_data_out[gi].tkeep  = packet_data_in.tkeep;
            assign packet_data_out[gi].tlast  = packet_data_in.tlast;
            assign packet_data_out[gi].tvalid = packet_data_in.tvalid && !sreset &&
                                                (state_reg == ST_FORWARD) &&
                                                (sel_port_reg == PORT_W'(gi));
            assign out_ready_vec[gi] = packet_data_out[gi].tready;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (sreset) begin
            state_reg         <= ST_IDLE;
            egr_reg           <= '0;
            ing_reg           <= '0;
            sel_port_reg      <= '0;
            fwd_cnt_reg       <= '0;
            drop_cnt_reg      <= '0;
            meta_overflow_reg <= 1'b0;
        end else begin
            meta_overflow_reg <= user_metadata_in_valid && fifo_full && !pop;
            case (state_reg)
                ST_IDLE: begin
                    // Head entry normally; with an empty FIFO a same-cycle strobe is
                    // looked through so its packet can start one cycle earlier. The
                    // strobe is still written and becomes the head popped at tlast.
                    if (!fifo_empty) begin
                        {egr_reg, ing_reg} <= fifo_rd_data;
                        state_reg          <= ST_DECIDE;
                    end else if (user_metadata_in_valid) begin
                        egr_reg   <= user_metadata_in_egr_spec;
                        ing_reg   <= user_metadata_in_ing_port;
                        state_reg <= ST_DECIDE;
                    end
                end
                ST_DECIDE: begin
                    sel_port_reg <= egr_reg[PORT_W-1:0];
                    state_reg    <= fwd_ok ? ST_FORWARD : ST_DROP;
                end
                ST_FORWARD: begin
                    if (pop) begin
                        fwd_cnt_reg <= sat_inc(fwd_cnt_reg);
                        state_reg   <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (pop) begin
                        drop_cnt_reg <= sat_inc(drop_cnt_reg);
                        state_reg    <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign fwd_pkt_count  = fwd_cnt_reg;
    assign drop_pkt_count = drop_cnt_reg;
    assign meta_overflow  = meta_overflow_reg;
endmodule

// File: doc/p4_router_egress_demux.md
P4_ROUTER_EGRESS_DEMUX -- requirements
Module: p4_router_egress_demux

Interface
REQ-001 The module SHALL have parameter NUM_PORTS, default 4: number of egress AXIS ports, range 2..16.
REQ-002 The module SHALL have parameter EGR_SPEC_METADATA_WIDTH, default 8: egress-spec field width, at least $clog2(NUM_PORTS).
REQ-003 The module SHALL have parameter ING_PORT_METADATA_WIDTH, default 8: ingress-port field width.
REQ-004 The module SHALL have parameter DATA_BYTES, default 64: AXIS width, equal to packet_data_in.DATA_BYTES and to each packet_data_out[i].DATA_BYTES.
REQ-005 The module SHALL have parameter LOOPBACK_EN, default 0: when 0, a packet whose egr_spec equals its ing_port is dropped.
REQ-006 The module SHALL have parameter META_FIFO_DEPTH, default 4: metadata buffer entries, a power of 2.
REQ-007 The module SHALL have port clk, input, 1: the only clock.
REQ-008 The module SHALL have port sreset, input, 1: reset, synchronous and active-high.
REQ-009 The module SHALL have port packet_data_in, AXIS_int.Slave: packets from the VNP4 wrapper.
REQ-010 The module SHALL have port user_metadata_in_egr_spec, input, EGR_SPEC_METADATA_WIDTH: egress spec, one per packet.
REQ-011 The module SHALL have port user_metadata_in_ing_port, input, ING_PORT_METADATA_WIDTH: ingress port.
REQ-012 The module SHALL have port user_metadata_in_valid, input, 1: single-cycle metadata strobe; it has no ready.
REQ-013 The module SHALL have port packet_data_out[NUM_PORTS], AXIS_int.Master array: egress ports.
REQ-014 The module SHALL have port fwd_pkt_count, output, 32: forwarded-packet count, saturating.
REQ-015 The module SHALL have port drop_pkt_count, output, 32: dropped-packet count, saturating.
REQ-016 The module SHALL have port meta_overflow, output, 1: one-cycle pulse when metadata is lost.

Function
REQ-017 Each metadata strobe SHALL push {egr_spec, ing_port} into a META_FIFO_DEPTH-entry FIFO; metadata may arrive at the same cycle as the first beat or earlier.
REQ-018 A strobe while the FIFO is full and not popping SHALL be discarded and SHALL pulse meta_overflow for 1 cycle; a simultaneous push and pop while full SHALL succeed.
REQ-019 The FSM SHALL have the states IDLE, DECIDE, FORWARD and DROP.
REQ-020 In IDLE, when the FIFO is non-empty, the FSM SHALL latch the head entry and go to DECIDE; packet_data_in.tready SHALL be 0 in IDLE and DECIDE.
REQ-021 In DECIDE, if egr_spec < NUM_PORTS and (LOOPBACK_EN=1 or egr_spec != ing_port), the FSM SHALL go to FORWARD with the selected port equal to egr_spec; otherwise it SHALL go to DROP (this includes the all-ones drop sentinel).
REQ-022 In FORWARD, the data, tvalid, tlast and tkeep of the selected port SHALL equal those of packet_data_in combinationally, packet_data_in.tready SHALL equal the selected port's tready, and all other ports SHALL hold tvalid at 0.
REQ-023 In DROP, packet_data_in.tready SHALL be 1 and every beat SHALL be discarded.
REQ-024 A beat accepted with tlast in FORWARD or DROP SHALL pop the FIFO, increment the matching counter and return the FSM to IDLE in the next cycle.
REQ-025 The minimum inter-packet overhead SHALL be 2 idle cycles (IDLE and DECIDE).
REQ-026 Counters SHALL saturate at 0xFFFF_FFFF and SHALL not wrap.
REQ-027 Beats arriving with the FIFO empty SHALL stall (tready=0) until metadata arrives; they SHALL never be dropped for lack of metadata.

Reset
REQ-028 On sreset the FSM SHALL return to IDLE, the FIFO SHALL empty, the counters SHALL clear to 0, meta_overflow and all out tvalid SHALL be 0, and packet_data_in.tready SHALL be 0.
REQ-029 A reset asserted mid-packet SHALL abort the packet, and the remaining beats SHALL wait in IDLE for fresh metadata; the upstream stage is reset together with this module.

Structure
REQ-030 The p4_router_pkg package SHALL hold the typedef egr_demux_state_t and the constant EGR_SPEC_DROP (all-ones).
REQ-031 The metadata FIFO SHALL be the sub-module p4_router_meta_fifo (synchronous, show-ahead, with full and empty flags).
REQ-032 The module SHALL carry elaboration checks on the DATA_BYTES equalities, on NUM_PORTS >= 2, and on EGR_SPEC_METADATA_WIDTH >= $clog2(NUM_PORTS).

Verification
REQ-033 The bench SHALL cover this case: metadata {egr=2, ing=0} followed by a 3-beat packet with all readies high -> the packet appears only on port 2, beats at cycles 2-4 after the strobe, and fwd_pkt_count=1.
REQ-034 The bench SHALL cover this case: egr=0xFF -> all beats are accepted with no out tvalid, drop_pkt_count=1; egr=1 with ing=1 and LOOPBACK_EN=0 -> the packet is dropped.
REQ-035 The bench SHALL cover this case: port 1 tready toggles randomly during a 10-beat packet -> data is intact in order, and packet_data_in.tready mirrors port 1 tready.
REQ-036 The bench SHALL cover this case: 5 strobes with no data and depth 4 -> one meta_overflow pulse on the 5th, and the next 4 packets route by the first 4 entries.
REQ-037 The bench SHALL cover this case: a 4-beat packet is aborted by sreset at beat 2, then new metadata egr=3 is sent -> the counters read 0 and the remaining beats route to port 3.
REQ-038 The bench SHALL cover this case: the counters are forced near 0xFFFF_FFFF and 2 packets are sent -> each counter holds at 0xFFFF_FFFF.
